lm32_dp_ram_reader: RTL

- Streaming read engine for the lm32 dual-port RAM read port.
- On a start command, it issues sequential read addresses from a base address for a given word count.
- It absorbs the RAM's one-cycle registered-address read latency and presents the words on a valid/ready stream with backpressure.
- It sits between the RAM read port and any consumer: trace dump, DMA-out, or debug readback.

---
 rtl/lm32_dp_ram_reader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lm32_dp_ram_reader.sv
// rtl/lm32_dp_ram_reader.sv - streaming read engine for the lm32 dual-port RAM read port
module lm32_dp_ram_reader #(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [addr_width-1:0] base_i,
    input  logic [addr_width:0]   len_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [addr_width-1:0] raddr_o,
    input  logic [data_width-1:0] rdata_i,
    output logic [data_width-1:0] data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [addr_width-1:0] addr_one = 1;
    localparam logic [addr_width:0]   len_one  = 1;
    localparam logic [addr_width:0]   len_zero = '0;

    state_t state_q, state_d;

    logic [addr_width-1:0] addr_q;
    logic [addr_width-1:0] raddr_q;
    logic [addr_width:0]   remaining_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    // Two-entry output FIFO kept as a head register plus one spill slot.
    logic [data_width-1:0] head_data_q;
    logic [data_width-1:0] tail_data_q;
    logic                  head_last_q;
    logic                  tail_last_q;
    logic [1:0]            count_q;

    logic       abort_act;
    logic       pop;
    logic       push;
    logic       issue;
    logic       last_issue;
    logic       drained;
    logic [2:0] pending;

    assign abort_act  = abort_i && (state_q != S_IDLE);
    assign pop        = valid_o && ready_i;
    assign push       = inflight_q;
    assign pending    = {1'b0, count_q} + {2'b00, inflight_q};
    // Words buffered plus in flight, net of this cycle's pop, must stay below two.
    assign issue      = (state_q == S_RUN) && !abort_i && (pending < (3'd2 + {2'b00, pop}));
    assign last_issue = issue && (remaining_q == len_one);
    assign drained    = !inflight_q && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != len_zero) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_RUN:   busy_o = 1'b1;
            S_DRAIN: busy_o = 1'b1;
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // The RAM registers raddr_o itself, so the issuing address goes out combinationally.
    assign raddr_o = issue ? addr_q : raddr_q;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_data_q;
    assign last_o  = head_last_q && valid_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q          <= '0;
            raddr_q         <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start_i) begin
                addr_q      <= base_i;
                remaining_q <= len_i;
            end else if (issue) begin
                addr_q      <= addr_q + addr_one;
                remaining_q <= remaining_q - len_one;
                raddr_q     <= addr_q;
            end
            if (abort_act) begin
                inflight_q      <= 1'b0;
                inflight_last_q <= 1'b0;
            end else begin
                inflight_q      <= issue;
                inflight_last_q <= last_issue;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_data_q <= '0;
            tail_data_q <= '0;
            head_last_q <= 1'b0;
            tail_last_q <= 1'b0;
            count_q     <= 2'd0;
        end else if (abort_act) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                        tail_data_q <= rdata_i;
                        tail_last_q <= inflight_last_q;
                    end else begin
                        head_data_q <= rdata_i;
                        head_last_q <= inflight_last_q;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_q <= rdata_i;
                        head_last_q <= inflight_last_q;
                    end else begin
                        tail_data_q <= rdata_i;
                        tail_last_q <= inflight_last_q;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_data_q <= tail_data_q;
                        head_last_q <= tail_last_q;
                    end
                    count_q <= count_q - 2'd1;
                end
                default: begin
                    count_q <= count_q;
                end
            endcase
        end
    end

endmodule
